// File: rtl/elastic_pipeline_register_if.sv
// Valid/ready handshake bundle for elastic_pipeline_register: upstream input side and downstream output side.
// The pipeline register itself uses the slave view; the producer/consumer pair uses the master view.
interface elastic_pipeline_register_if #(
    parameter int unsigned PIPE_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PIPE_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [PIPE_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/elastic_pipeline_register.sv
// DEPTH-stage elastic pipeline register with per-stage valid/ready, bubble collapsing,
// synchronous flush, registered occupancy count and a simulation-only scan print.
module elastic_pipeline_register #(
    parameter int unsigned           PIPELINE_STAGE  = 0,
    parameter int unsigned           PIPE_WIDTH      = 32,
    parameter int unsigned           DEPTH           = 2,
    parameter logic [PIPE_WIDTH-1:0] RESET_VALUE     = '0,
    parameter int unsigned           SCAN_CYCLES_MIN = 1,
    parameter int unsigned           SCAN_CYCLES_MAX = 1000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [PIPE_WIDTH-1:0]        flush_input,
    elastic_pipeline_register_if.slave   bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    input  logic                         scan
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      r_valid;
    logic [PIPE_WIDTH-1:0] r_data [DEPTH];
    logic [OCC_W-1:0]      r_occ;

    logic [DEPTH:0]        w_rdy;
    logic [DEPTH-1:0]      w_up_valid;
    logic [PIPE_WIDTH-1:0] w_up_data [DEPTH];
    logic                  w_in_xfer;
    logic                  w_out_xfer;

    // Ready ripples from the output back to the input; an empty stage is always ready.
    always_comb begin
        logic w_acc;
        w_rdy        = '0;
        w_acc        = bus.out_ready;
        w_rdy[DEPTH] = bus.out_ready;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_acc              = ~r_valid[DEPTH-1-i] | w_acc;
            w_rdy[DEPTH-1-i]   = w_acc;
        end
    end

    always_comb begin
        w_up_valid[0] = bus.in_valid;
        w_up_data[0]  = bus.in_data;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_up_valid[k] = r_valid[k-1];
            w_up_data[k]  = r_data[k-1];
        end
    end

    always_comb begin
        bus.out_data  = r_data[DEPTH-1];
        bus.out_valid = r_valid[DEPTH-1] & ~flush;
        bus.in_ready  = w_rdy[0] & ~flush;
        w_in_xfer     = bus.in_valid & bus.in_ready;
        w_out_xfer    = bus.out_valid & bus.out_ready;
        occupancy     = r_occ;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_data[k] <= RESET_VALUE;
            end
        end else if (flush) begin
            r_valid <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_data[k] <= flush_input;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (w_rdy[k]) begin
                    r_valid[k] <= w_up_valid[k];
                    if (w_up_valid[k]) begin
                        r_data[k] <= w_up_data[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

`ifndef SYNTHESIS
    logic [31:0] r_scan_cycle;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scan_cycle <= '0;
        end else begin
            r_scan_cycle <= r_scan_cycle + 32'd1;
            if (scan && (r_scan_cycle >= SCAN_CYCLES_MIN) && (r_scan_cycle <= SCAN_CYCLES_MAX)) begin
                $display("scan stage=%0d cycle=%0d valid=%b in_data=%h out_data=%h in_ready=%b out_ready=%b flush=%b occupancy=%0d",
                         PIPELINE_STAGE, r_scan_cycle, r_valid, bus.in_data, bus.out_data,
                         bus.in_ready, bus.out_ready, flush, r_occ);
            end
        end
    end
`endif
endmodule

// File: doc/elastic_pipeline_register.md
# elastic_pipeline_register

Parametrised, multi-stage successor to the single-stage stall/flush pipeline register. It replaces the global `stall` with a per-stage valid/ready handshake and bubble collapsing, and holds up to `DEPTH` beats. Flush, a scan debug print and an occupancy count are retained or added. It sits between core pipeline stages, or between a stage and a memory/bus interface, wherever backpressure must be absorbed without a global stall.

## Interface
- `PIPELINE_STAGE`, 0: stage identifier printed by scan.
- `PIPE_WIDTH`, 32: data width in bits.
- `DEPTH`, 2: number of register stages; legal range is 1 or more.
- `RESET_VALUE`, 0: value loaded into every data register on reset.
- `SCAN_CYCLES_MIN`, 1: first cycle for scan printing.
- `SCAN_CYCLES_MAX`, 1000: last cycle for scan printing.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous flush of all stages.
- `flush_input`  in  PIPE_WIDTH  value loaded into every data register on flush.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `in_data`  in  PIPE_WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a live beat.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  PIPE_WIDTH  payload at the output stage.
- `occupancy`  out  $clog2(DEPTH+1)  number of live beats held.
- `scan`  in  1  enables the simulation-only state print.

## Operation
- State per stage k, with k=0 at the input and k=DEPTH-1 at the output: `valid[k]` and `data[k]`.
- `out_data = data[DEPTH-1]`.
- `out_valid = valid[DEPTH-1] & ~flush`.
- Ready chain: `rdy[DEPTH] = out_ready`; `rdy[k] = ~valid[k] | rdy[k+1]`.
- `in_ready = rdy[0] & ~flush`. The path is combinational from `out_ready` and `flush`.
- Stage update when `rdy[k]` is high: `valid[k] <= up_valid`, where the upstream is `in_valid` for k=0 and `valid[k-1]` otherwise.
  - `data[k]` loads the upstream data only when `up_valid` is high; otherwise it holds.
  - When `rdy[k]` is low, the stage holds both `valid[k]` and `data[k]`.
- Bubble collapsing: an empty stage always accepts, even when downstream stages are stalled.
- Input transfer is `in_valid & in_ready`. Output transfer is `out_valid & out_ready`. Beats leave in strict FIFO order, with no loss and no duplication.
- Flush takes priority over all handshake activity:
  - Every `valid[k]` is cleared and every `data[k]` loads `flush_input`.
  - `occupancy` goes to 0.
  - A beat offered during the flush cycle is not accepted.
  - No output transfer occurs in the flush cycle.
- `occupancy` is a registered counter:
  - +1 on an input transfer, -1 on an output transfer, unchanged when both happen in the same cycle.
  - It always equals the popcount of `valid`; the bench checks this every cycle.
  - It never exceeds `DEPTH`, and it never wraps.
- Scan (simulation only, no synthesised logic): when `scan` is high and the internal cycle counter lies within [`SCAN_CYCLES_MIN`, `SCAN_CYCLES_MAX`], the block `$display`s the following each cycle:
  - `PIPELINE_STAGE`
  - the `valid` bits
  - `in_data` and `out_data`
  - `in_ready` and `out_ready`
  - `flush` and `occupancy`

## Timing
- Reset, effective immediately and independent of `clock`:
  - `valid` = 0, `data` = `RESET_VALUE`, `occupancy` = 0.
  - Hence `out_valid` = 0, `out_data` = `RESET_VALUE`, and `in_ready` = 1 (unless `flush` is high).
- Reset asserted mid-stream discards all beats. The first accept after deassertion is possible on the first rising edge.
- Latency: a beat accepted at edge N into an empty pipe with `out_ready` high shows `out_valid` after edge N+DEPTH-1, i.e. DEPTH register stages from `in_data`.
- Throughput: one beat per cycle while `out_ready` is high.
- Full: all valid and `out_ready` low gives `in_ready` = 0. On the cycle `out_ready` rises, `in_ready` = 1, so a simultaneous accept and release occurs with no bubble.
- Flush and `out_ready` in the same cycle: the flush wins and nothing is emitted.
- Flush and reset together: reset wins.
- DEPTH=1: the block behaves as a single register with a combinational `in_ready = (~valid | out_ready) & ~flush`.

## Test plan
- Reset: hold `reset` high for 3 cycles, DEPTH=2. Require `out_valid`=0, `out_data`=0, `in_ready`=1 and `occupancy`=0 throughout, including immediately after an asynchronous assertion mid-cycle.
- Streaming: DEPTH=2, `out_ready`=1, `in_valid`=1, `in_data` = 1, 2, 3, … per cycle. Require `out_data` = 1, 2, 3, … in order with no gaps, first `out_valid` 2 edges after the first accept, and `occupancy`=2 in steady state.
- Backpressure: while streaming, drop `out_ready` for 3 cycles. Require:
  - `out_data` holds its value.
  - `in_ready` falls once `occupancy`=2.
  - On `out_ready` rising, delivery resumes with no missing or duplicated value.
- Bubble collapse: DEPTH=3, `out_ready`=0, send beats 10 then 11 two cycles apart. Require both stored, `occupancy`=2 and `in_ready`=1. When `out_ready` rises, the outputs are 10 then 11.
- Flush: with 2 live beats and `flush_input`=32'h00000013, pulse `flush` for 1 cycle with `in_valid`=1. Require:
  - `in_ready`=0 and `out_valid`=0 during the flush cycle.
  - Afterwards, `occupancy`=0, `out_data`=32'h00000013, and the beat offered during the flush is absent.
  - The next beat arrives normally.
- Reset mid-stream: assert `reset` asynchronously between edges with 2 beats live. Require `out_valid` low before the next edge, then a clean restart yielding only new beats.
